data_input: RTL and testbench
=============================

# data_input

Input-side port block for the lab I/O board: samples the 16 board switches, synchronises and debounces them in four 4-bit nibbles, and returns one nibble per read on a 4-bit data bus addressed by a 2-bit port ID. It is the read counterpart of the nibble-addressed indicator output port and shares its addressing: port 0 = bits [3:0] through port 3 = bits [15:12]. Per-port change flags report a stable nibble that has changed and not yet been read.

## Interface
- DEBOUNCE_CYCLES, 50000, consecutive cycles a nibble must differ from its stable value before it is accepted (legal range 1..65535).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES - 1.

- clk  input  1  clock.
- Reset  input  1  reset, synchronous, active-high.
- Switch  input  16  raw asynchronous switch levels.
- rd  input  1  read strobe, sampled every rising edge.
- PortID  input  2  nibble select for the read.
- Data  output  4  registered read data.
- DataValid  output  1  one-cycle pulse: Data holds a fresh read result.
- Changed  output  4  per-port flag: stable nibble changed since that port's last read.
- Irq  output  1  OR of Changed.

## Operation
- Synchroniser: two flops per bit, s1 <= Switch, s2 <= s1.
- Per nibble n there is a stable register stable[n] (4 bits) and a counter cnt[n] (CNT_W bits).
- Debounce, evaluated per nibble on each edge:
  - s2 nibble == stable[n]: cnt[n] <= 0.
  - s2 nibble != stable[n] and cnt[n] < DEBOUNCE_CYCLES-1: cnt[n] increments.
  - s2 nibble != stable[n] and cnt[n] == DEBOUNCE_CYCLES-1: stable[n] <= s2 nibble, cnt[n] <= 0, Changed[n] <= 1.
  - A bounce back to stable[n] before acceptance clears the counter. The count restarts, with no partial credit.
  - A different non-stable value mid-count does not reset the counter, because the comparison is against stable[n] only. Whatever value s2 holds at acceptance is taken.
- Read: when rd=1 at an edge:
  - Data <= stable[PortID].
  - DataValid <= 1.
  - Changed[PortID] <= 0.
- When rd=0 at an edge, DataValid <= 0 and Data holds its last value.
- Holding rd high for several cycles performs one read per cycle. PortID may change on every cycle.
- Simultaneous acceptance on nibble n and a read of port n at the same edge:
  - Data returns the old stable value.
  - Changed[n] ends at 1; the set wins over the clear.
  - Reads of other ports are unaffected.
- Irq = |Changed, purely combinational from the Changed register.

## Timing
- Reset (synchronous, takes priority over everything): s1, s2, all stable, all cnt, Data, DataValid and Changed go to 0. Irq is therefore 0.
- Reset asserted mid-count discards the partial count.
- After reset, switches held at a non-zero value are accepted as a change after the normal debounce latency, so Changed sets for those nibbles.
- Read latency: rd at edge t gives Data/DataValid valid after edge t, i.e. for the cycle t..t+1. DataValid is high for exactly one cycle per rd cycle.
- Acceptance latency with debounce: a Switch change sampled into s1 at edge t, and held, updates stable[n] and sets Changed[n] at edge t+1+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=1 this is edge t+2.
- The four nibbles debounce independently, and several may accept at the same edge.

## Configuration
- DATAINPUT_DEBOUNCE_EN defined: debounce counters are built and behave as above.
- DATAINPUT_DEBOUNCE_EN undefined:
  - Counters are not instantiated, and DEBOUNCE_CYCLES and CNT_W are ignored.
  - stable <= s2 every edge, so latency is edge t+2.
  - Changed[n] sets at any edge where the s2 nibble != stable[n].
  - The read, flag, priority and reset rules are unchanged.

## Test plan
- Reset with Switch=16'h0000, then rd with PortID=0..3 on consecutive cycles: Data=0 each cycle, DataValid high for 4 consecutive cycles, Changed=0, Irq=0.
- DEBOUNCE_CYCLES=4, macro defined, Switch set to 16'hA5C3 at edge t:
  - No Changed bit is set before edge t+5.
  - At edge t+5, Changed=4'b1111 and Irq=1.
  - Reading port 2 returns 4'h5 and clears only Changed[2].
- Bounce: nibble 0 toggles 0→1→0→1 with 2-cycle holds (DEBOUNCE_CYCLES=4): stable[0] stays 0. Then holding 1 is accepted exactly 5 edges after the last sampled transition.
- Simultaneous: rd for port 1 at the same edge nibble 1 accepts 4'h7 over old 4'h2: Data=4'h2 and Changed[1]=1. The next read returns 4'h7 and clears Changed[1].
- Reset mid-count: Switch nibble 3 changes, then Reset asserts at count 2: all outputs are 0 afterward. Re-acceptance takes the full latency measured from reset release.
- Macro undefined: Switch=16'h000F sampled at edge t gives Changed[0]=1 at edge t+2, and a read of port 0 returns 4'hF.

Source files
------------

// File: rtl/data_input_if.sv
// Switch/read bus for the data_input port block: raw switches in, nibble read port out.
interface data_input_if;
  logic [15:0] Switch;
  logic        rd;
  logic [1:0]  PortID;
  logic [3:0]  Data;
  logic        DataValid;
  logic [3:0]  Changed;
  logic        Irq;

  modport master (
    output Switch, rd, PortID,
    input  Data, DataValid, Changed, Irq
  );

  modport slave (
    input  Switch, rd, PortID,
    output Data, DataValid, Changed, Irq
  );
endinterface

// File: rtl/data_input.sv
// Board switch input port: sync, per-nibble debounce, nibble-addressed reads with change flags.
// Optional debounce counters are built when DATAINPUT_DEBOUNCE_EN is defined.
module data_input #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic         clk,
  input logic         Reset,
  data_input_if.slave bus
);

  logic [15:0] sw_p0;
  logic [15:0] sw_p1;
  logic [15:0] stable;
  logic [3:0]  accept;
  logic [3:0]  data_p2;
  logic        vld_p2;
  logic [3:0]  changed;
  logic [3:0]  clr;

  // Stage p0/p1: two-flop synchroniser on the raw switch levels
  always_ff @(posedge clk) begin
    if (Reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= bus.Switch;
      sw_p1 <= sw_p0;
    end
  end

`ifdef DATAINPUT_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [4];

  always_comb begin
    accept = '0;
    for (int n = 0; n < 4; n++)
      accept[n] = (sw_p1[n*4 +: 4] != stable[n*4 +: 4]) && (cnt[n] == CNT_MAX);
  end

  // Count compares against the stable value only, so a new non-stable value keeps the count.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (Reset)
        cnt[n] <= '0;
      else if ((sw_p1[n*4 +: 4] == stable[n*4 +: 4]) || accept[n])
        cnt[n] <= '0;
      else
        cnt[n] <= cnt[n] + 1'b1;
    end
  end
`else
  always_comb begin
    accept = '0;
    for (int n = 0; n < 4; n++)
      accept[n] = (sw_p1[n*4 +: 4] != stable[n*4 +: 4]);
  end
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      stable <= '0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (accept[n])
          stable[n*4 +: 4] <= sw_p1[n*4 +: 4];
    end
  end

  always_comb begin
    clr = '0;
    if (bus.rd)
      clr = 4'b0001 << bus.PortID;
  end

  // Stage p2: registered read result; a same-edge acceptance returns the old value
  // and its flag set beats the read's clear.
  always_ff @(posedge clk) begin
    if (Reset) begin
      data_p2 <= '0;
      vld_p2  <= 1'b0;
      changed <= '0;
    end else begin
      vld_p2  <= bus.rd;
      if (bus.rd)
        data_p2 <= stable[bus.PortID*4 +: 4];
      changed <= (changed & ~clr) | accept;
    end
  end

  assign bus.Data      = data_p2;
  assign bus.DataValid = vld_p2;
  assign bus.Changed   = changed;
  assign bus.Irq       = |changed;

endmodule

// File: tb/tb_data_input.sv
// Bench for data_input: directed scenarios plus random traffic against a behavioural model.
module tb_data_input;

  localparam int DEB = 4;
`ifdef DATAINPUT_DEBOUNCE_EN
  localparam int MD = DEB;
`else
  localparam int MD = 1;
`endif
  // Edges from the switch being sampled to the nibble being accepted.
  localparam int LAT = 1 + MD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_input_if bus();

  data_input #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: sampled switch delay line, accepted nibbles, run of differing samples.
  logic [15:0] m_s1, m_s2, m_stable;
  int          m_run [4];
  logic [3:0]  m_data, m_chg;
  logic        m_dv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input logic r, input logic [15:0] sw, input logic rdv,
                            input logic [1:0] pid);
    logic [3:0]  set;
    logic [15:0] nst;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      for (int n = 0; n < 4; n++) m_run[n] = 0;
      m_data = '0; m_dv = 1'b0; m_chg = '0;
    end else begin
      set = '0;
      nst = m_stable;
      m_dv = rdv;
      if (rdv) begin
        m_data = m_stable[pid*4 +: 4];
        m_chg[pid] = 1'b0;
      end
      for (int n = 0; n < 4; n++) begin
        if (m_s2[n*4 +: 4] == m_stable[n*4 +: 4]) m_run[n] = 0;
        else begin
          m_run[n]++;
          if (m_run[n] == MD) begin
            nst[n*4 +: 4] = m_s2[n*4 +: 4];
            m_run[n] = 0;
            set[n] = 1'b1;
          end
        end
      end
      m_chg    = m_chg | set;
      m_stable = nst;
      m_s2     = m_s1;
      m_s1     = sw;
    end
  endtask

  task automatic step(input logic r, input logic [15:0] sw, input logic rdv, input logic [1:0] pid);
    rst        = r;
    bus.Switch = sw;
    bus.rd     = rdv;
    bus.PortID = pid;
    @(posedge clk);
    model_edge(r, sw, rdv, pid);
    #1;
    check("dv", bus.DataValid, m_dv);
    check("data", bus.Data, m_data);
    check("changed", bus.Changed, m_chg);
    check("irq", bus.Irq, |m_chg);
  endtask

  initial begin
    logic [15:0] sw;
    // Reset state and back-to-back reads of all four ports
    step(1, 16'h0000, 0, 0);
    step(1, 16'h0000, 0, 0);
    check("rst_chg", bus.Changed, 4'h0);
    for (int p = 0; p < 4; p++) begin
      step(0, 16'h0000, 1, 2'(p));
      check("rd0_data", bus.Data, 4'h0);
      check("rd0_dv", bus.DataValid, 1'b1);
      check("rd0_chg", bus.Changed, 4'h0);
      check("rd0_irq", bus.Irq, 1'b0);
    end
    step(0, 16'h0000, 0, 0);
    check("dv_drop", bus.DataValid, 1'b0);

    // All four nibbles accept together after the full latency
    step(0, 16'hA5C3, 0, 0);
    for (int k = 1; k < LAT; k++) begin
      step(0, 16'hA5C3, 0, 0);
      check("early_chg", bus.Changed, 4'h0);
    end
    step(0, 16'hA5C3, 0, 0);
    check("acc_chg", bus.Changed, 4'hF);
    check("acc_irq", bus.Irq, 1'b1);
    step(0, 16'hA5C3, 1, 2);
    check("rd2_data", bus.Data, 4'h5);
    check("rd2_chg", bus.Changed, 4'b1011);

    // Bounce on nibble 0, then a held value
    step(1, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 0);
    for (int b = 0; b < 4; b++) begin
      step(0, 16'h0001, 0, 0);
      step(0, 16'h0001, 0, 0);
      step(0, 16'h0000, 0, 0);
      step(0, 16'h0000, 0, 0);
`ifdef DATAINPUT_DEBOUNCE_EN
      check("bounce_chg", bus.Changed, 4'h0);
`endif
    end
    step(0, 16'h0001, 0, 0);
    for (int k = 1; k < LAT; k++) begin
      step(0, 16'h0001, 0, 0);
`ifdef DATAINPUT_DEBOUNCE_EN
      check("bounce_early", bus.Changed, 4'h0);
`endif
    end
    step(0, 16'h0001, 0, 0);
    check("bounce_acc", bus.Changed[0], 1'b1);
    step(0, 16'h0001, 1, 0);
    check("bounce_data", bus.Data, 4'h1);

    // Acceptance and read of the same nibble at one edge
    step(1, 16'h0020, 0, 0);
    for (int k = 0; k <= LAT; k++) step(0, 16'h0020, 0, 0);
    step(0, 16'h0020, 1, 1);
    check("sim_pre", bus.Data, 4'h2);
    step(0, 16'h0070, 0, 0);
    for (int k = 1; k < LAT; k++) step(0, 16'h0070, 0, 0);
    step(0, 16'h0070, 1, 1);
    check("sim_data", bus.Data, 4'h2);
    check("sim_chg", bus.Changed[1], 1'b1);
    step(0, 16'h0070, 1, 1);
    check("sim_data2", bus.Data, 4'h7);
    check("sim_chg2", bus.Changed[1], 1'b0);

    // Reset in the middle of a count
    step(1, 16'h0000, 0, 0);
    step(0, 16'h0000, 1, 0);
    step(0, 16'h3000, 0, 0);
    for (int k = 1; k <= 3; k++) step(0, 16'h3000, k == 3, 2'd3);
    step(1, 16'h3000, 0, 0);
    check("mrst_data", bus.Data, 4'h0);
    check("mrst_dv", bus.DataValid, 1'b0);
    check("mrst_chg", bus.Changed, 4'h0);
    check("mrst_irq", bus.Irq, 1'b0);
    step(0, 16'h3000, 0, 0);
    for (int k = 1; k < LAT; k++) begin
      step(0, 16'h3000, 0, 0);
      check("mrst_early", bus.Changed, 4'h0);
    end
    step(0, 16'h3000, 0, 0);
    check("mrst_acc", bus.Changed, 4'b1000);

    // Low nibble all ones
    step(1, 16'h0000, 0, 0);
    step(0, 16'h000F, 0, 0);
    for (int k = 1; k < LAT; k++) step(0, 16'h000F, 0, 0);
    step(0, 16'h000F, 0, 0);
    check("f_chg", bus.Changed, 4'h1);
    step(0, 16'h000F, 1, 0);
    check("f_data", bus.Data, 4'hF);

    // Random traffic: slow switch changes with occasional single-nibble glitches
    sw = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
      else if ($urandom_range(0, 5) == 0) sw[$urandom_range(0, 15)] ^= 1'b1;
      step($urandom_range(0, 150) == 0, sw, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
